// File: rtl/scaler_readout_sequencer.sv
// -----------------------------------------------------------------------------
// scaler_readout_sequencer
//
// WISHBONE master that reads the whole scaler byte map after every PPS-driven
// scaler update, packs byte pairs into 16-bit words and emits one framed
// valid/ready stream: a header word {HEADER_ID, seq}, then NUM_BYTES/2 data
// words {hi, lo}.
//
// Optional feature macro: SCALER_READOUT_CHECKSUM_EN
//   undefined : last_o is asserted on the final data word.
//   defined   : a trailing word carries the two's complement of the 16-bit
//               running sum of all data words, so data words + checksum == 0.
//
// Reads are single classic WB cycles with at least one idle cycle between
// them. A missing ack (ACK_TIMEOUT cycles) or err_i substitutes 8'hFF for the
// byte and sets the sticky bus_err_o, and the frame carries on.
// -----------------------------------------------------------------------------
module scaler_readout_sequencer #(
  parameter logic [15:0] BASE_ADR    = 16'h0100,
  parameter int          NUM_BYTES   = 104,
  parameter int          ACK_TIMEOUT = 15,
  parameter logic [7:0]  HEADER_ID   = 8'hA5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        update_i,
  input  logic        enable_i,
  input  logic [7:0]  holdoff_i,
  input  logic        clear_i,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        wr_o,
  output logic [15:0] adr_o,
  input  logic [7:0]  dat_i,
  input  logic        ack_i,
  input  logic        err_i,
  output logic [15:0] dat_o,
  output logic        valid_o,
  output logic        last_o,
  input  logic        ready_i,
  output logic        busy_o,
  output logic        overrun_o,
  output logic        bus_err_o
);

  localparam int IDX_W = $clog2(NUM_BYTES + 1);
  localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLDOFF,
    S_HEADER,
    S_RD_LO,
    S_RD_HI,
    S_PUSH,
    S_CKSUM,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [7:0]       r_hold;
  logic [IDX_W-1:0] r_idx;
  logic [TO_W-1:0]  r_to;
  logic [7:0]       r_lo;
  logic [7:0]       r_seq;
  logic             r_pending;
  logic             r_overrun;
  logic             r_bus_err;
  logic             r_cyc;
  logic             r_stb;
  logic [15:0]      r_adr;
  logic [15:0]      r_dat;
  logic             r_valid;
  logic             r_last;
  logic             r_busy;
`ifdef SCALER_READOUT_CHECKSUM_EN
  logic [15:0]      r_sum;
`endif

  logic             w_timeout;
  logic             w_rd_done;
  logic             w_fault;
  logic [7:0]       w_byte;
  logic [IDX_W-1:0] w_next_idx;
  logic             w_upd_busy;

  // A strobed read finishes on ack, on err, or when the ack wait expires.
  assign w_timeout  = (r_to == TO_W'(ACK_TIMEOUT - 1));
  assign w_rd_done  = r_stb & (ack_i | err_i | w_timeout);
  assign w_fault    = r_stb & (err_i | (!ack_i & w_timeout));
  assign w_byte     = (err_i || !ack_i) ? 8'hFF : dat_i;
  assign w_next_idx = r_idx + IDX_W'(1);
  assign w_upd_busy = update_i & (r_state != S_IDLE);

  assign cyc_o     = r_cyc;
  assign stb_o     = r_stb;
  assign wr_o      = 1'b0;
  assign adr_o     = r_adr;
  assign dat_o     = r_dat;
  assign valid_o   = r_valid;
  assign last_o    = r_last;
  assign busy_o    = r_busy;
  assign overrun_o = r_overrun;
  assign bus_err_o = r_bus_err;

  // Sequencer FSM with registered bus/stream outputs and sticky status.
  // NOTE: every register here uses <= so all updates see pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_hold    <= '0;
      r_idx     <= '0;
      r_to      <= '0;
      r_lo      <= '0;
      r_seq     <= '0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
      r_bus_err <= 1'b0;
      r_cyc     <= 1'b0;
      r_stb     <= 1'b0;
      r_adr     <= BASE_ADR;
      r_dat     <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
`ifdef SCALER_READOUT_CHECKSUM_EN
      r_sum     <= '0;
`endif
    end else begin
      // Sticky flags: a set event in the same cycle as clear_i wins.
      if (w_upd_busy)   r_overrun <= 1'b1;
      else if (clear_i) r_overrun <= 1'b0;
      if (w_fault)      r_bus_err <= 1'b1;
      else if (clear_i) r_bus_err <= 1'b0;
      if (w_upd_busy)   r_pending <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (update_i && enable_i) begin
            r_hold  <= holdoff_i;
            r_busy  <= 1'b1;
            r_state <= S_HOLDOFF;
          end
        end

        // holdoff_i of 0 or 1 both give a single HOLDOFF cycle.
        S_HOLDOFF: begin
          if (r_hold <= 8'd1) begin
            r_valid <= 1'b1;
            r_dat   <= {HEADER_ID, r_seq};
            r_last  <= 1'b0;
            r_state <= S_HEADER;
          end else begin
            r_hold <= r_hold - 8'd1;
          end
        end

        S_HEADER: begin
          if (ready_i) begin
            r_valid <= 1'b0;
            r_seq   <= r_seq + 8'd1;
            r_idx   <= '0;
            r_adr   <= BASE_ADR;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_to    <= '0;
`ifdef SCALER_READOUT_CHECKSUM_EN
            r_sum   <= '0;
`endif
            r_state <= S_RD_LO;
          end
        end

        // Entering RD_HI drops the strobe, so it re-issues after one idle cycle.
        S_RD_LO, S_RD_HI: begin
          if (!r_stb) begin
            r_cyc <= 1'b1;
            r_stb <= 1'b1;
            r_to  <= '0;
          end else if (w_rd_done) begin
            r_cyc <= 1'b0;
            r_stb <= 1'b0;
            r_to  <= '0;
            r_idx <= w_next_idx;
            r_adr <= BASE_ADR + 16'(w_next_idx);
            if (r_state == S_RD_LO) begin
              r_lo    <= w_byte;
              r_state <= S_RD_HI;
            end else begin
              r_valid <= 1'b1;
              r_dat   <= {w_byte, r_lo};
`ifdef SCALER_READOUT_CHECKSUM_EN
              r_last  <= 1'b0;
`else
              r_last  <= (w_next_idx == IDX_W'(NUM_BYTES));
`endif
              r_state <= S_PUSH;
            end
          end else begin
            r_to <= r_to + TO_W'(1);
          end
        end

        S_PUSH: begin
          if (ready_i) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
`ifdef SCALER_READOUT_CHECKSUM_EN
            r_sum   <= r_sum + r_dat;
`endif
            if (r_idx == IDX_W'(NUM_BYTES)) begin
`ifdef SCALER_READOUT_CHECKSUM_EN
              r_valid <= 1'b1;
              r_last  <= 1'b1;
              r_dat   <= 16'd0 - (r_sum + r_dat);
              r_state <= S_CKSUM;
`else
              r_state <= S_DONE;
`endif
            end else begin
              r_cyc   <= 1'b1;
              r_stb   <= 1'b1;
              r_to    <= '0;
              r_state <= S_RD_LO;
            end
          end
        end

`ifdef SCALER_READOUT_CHECKSUM_EN
        S_CKSUM: begin
          if (ready_i) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_state <= S_DONE;
          end
        end
`endif

        // A held (or coincident) update restarts only if still enabled;
        // either way the single pending slot is consumed here.
        S_DONE: begin
          r_pending <= 1'b0;
          if ((r_pending || update_i) && enable_i) begin
            r_hold  <= holdoff_i;
            r_state <= S_HOLDOFF;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scaler_readout_sequencer.sv
// -----------------------------------------------------------------------------
// Directed bench for scaler_readout_sequencer. A WB slave model returns
// byte = adr[7:0] (optionally withholding ack or raising err on one address),
// a stream sink collects accepted words, and each frame is compared against
// expected words computed here from that byte mapping.
// Honors SCALER_READOUT_CHECKSUM_EN (frame grows to 54 words).
// -----------------------------------------------------------------------------
module tb_scaler_readout_sequencer;

  localparam int NUM_BYTES = 104;
`ifdef SCALER_READOUT_CHECKSUM_EN
  localparam int FRAME_LEN = NUM_BYTES / 2 + 2;
`else
  localparam int FRAME_LEN = NUM_BYTES / 2 + 1;
`endif
  localparam logic [15:0] NO_ADR = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        update_i = 1'b0;
  logic        enable_i = 1'b1;
  logic [7:0]  holdoff_i = 8'd3;
  logic        clear_i = 1'b0;
  logic        cyc_o, stb_o, wr_o;
  logic [15:0] adr_o;
  logic [7:0]  dat_i = 8'h00;
  logic        ack_i = 1'b0;
  logic        err_i = 1'b0;
  logic [15:0] dat_o;
  logic        valid_o, last_o;
  logic        ready_i = 1'b1;
  logic        busy_o, overrun_o, bus_err_o;

  scaler_readout_sequencer dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .update_i  (update_i),
    .enable_i  (enable_i),
    .holdoff_i (holdoff_i),
    .clear_i   (clear_i),
    .cyc_o     (cyc_o),
    .stb_o     (stb_o),
    .wr_o      (wr_o),
    .adr_o     (adr_o),
    .dat_i     (dat_i),
    .ack_i     (ack_i),
    .err_i     (err_i),
    .dat_o     (dat_o),
    .valid_o   (valid_o),
    .last_o    (last_o),
    .ready_i   (ready_i),
    .busy_o    (busy_o),
    .overrun_o (overrun_o),
    .bus_err_o (bus_err_o)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Slave / sink configuration and observations.
  int          ready_mode = 0;
  logic [15:0] no_ack_adr = NO_ADR;
  logic [15:0] err_adr    = NO_ADR;
  logic [15:0] q_dat[$];
  bit          q_last[$];
  bit          st_pend = 0;
  logic [15:0] st_dat;
  logic        st_last;
  bit          prev_done = 0;
  int          n_stalls = 0;
  int          gap_viol = 0;
  int          overlap = 0;
  int          to_len = 0;
  int          first_stb_cyc = -1;
  int          first_valid_cyc = -1;
  int          upd_cyc = 0;

  // Outputs are sampled on the falling edge; responses set here are what the
  // DUT sees at the following rising edge.
  always @(negedge clk) begin
    if (st_pend) begin
      check("stall_valid", valid_o, 1'b1);
      check("stall_dat", dat_o, st_dat);
      check("stall_last", last_o, st_last);
    end
    if (prev_done && stb_o) gap_viol++;
    if (valid_o && stb_o) overlap++;

    if (cyc_o && stb_o) begin
      if (first_stb_cyc < 0) first_stb_cyc = cyc_cnt;
      dat_i = adr_o[7:0];
      if (adr_o == no_ack_adr) begin
        ack_i = 1'b0; err_i = 1'b0; to_len++;
      end else if (adr_o == err_adr) begin
        ack_i = 1'b0; err_i = 1'b1;
      end else begin
        ack_i = 1'b1; err_i = 1'b0;
      end
    end else begin
      ack_i = 1'b0; err_i = 1'b0; dat_i = 8'h00;
    end
    prev_done = ack_i || err_i;

    ready_i = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    if (valid_o && first_valid_cyc < 0) first_valid_cyc = cyc_cnt;
    if (valid_o && ready_i) begin
      q_dat.push_back(dat_o);
      q_last.push_back(last_o);
    end
    st_pend = valid_o && !ready_i;
    if (st_pend) n_stalls++;
    st_dat  = dat_o;
    st_last = last_o;
  end

  function automatic logic [7:0] exp_byte(input int i, input logic [15:0] bad_a,
                                          input logic [15:0] err_a);
    logic [15:0] a;
    a = 16'h0100 + 16'(i);
    if (a == bad_a || a == err_a) return 8'hFF;
    return a[7:0];
  endfunction

  task automatic check_frame(input logic [7:0] seq, input int base,
                             input logic [15:0] bad_a, input logic [15:0] err_a);
    logic [15:0] w;
    int last_pos, last_cnt;
`ifdef SCALER_READOUT_CHECKSUM_EN
    logic [15:0] sum;
    sum = '0;
`endif
    if (q_dat.size() < base + FRAME_LEN) begin
      check($sformatf("f%0d_size", seq), q_dat.size(), base + FRAME_LEN);
      return;
    end
    check($sformatf("f%0d_header", seq), q_dat[base], {8'hA5, seq});
    for (int k = 0; k < NUM_BYTES / 2; k++) begin
      w = {exp_byte(2 * k + 1, bad_a, err_a), exp_byte(2 * k, bad_a, err_a)};
`ifdef SCALER_READOUT_CHECKSUM_EN
      sum = sum + w;
`endif
      check($sformatf("f%0d_word%0d", seq, k), q_dat[base + 1 + k], w);
    end
`ifdef SCALER_READOUT_CHECKSUM_EN
    check($sformatf("f%0d_cksum", seq), q_dat[base + FRAME_LEN - 1], 16'd0 - sum);
`endif
    last_pos = -1;
    last_cnt = 0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (q_last[base + i]) begin
        last_cnt++;
        last_pos = i;
      end
    end
    check($sformatf("f%0d_last_cnt", seq), last_cnt, 1);
    check($sformatf("f%0d_last_pos", seq), last_pos, FRAME_LEN - 1);
  endtask

  // Called just after a falling edge; the pulse covers one rising edge.
  task automatic send_update();
    update_i = 1'b1;
    upd_cyc  = cyc_cnt;
    @(negedge clk);
    update_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, busy_o, 1'b0);
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bit found;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_cyc", cyc_o, 1'b0);
    check("rst_stb", stb_o, 1'b0);
    check("rst_wr", wr_o, 1'b0);
    check("rst_adr", adr_o, 16'h0100);
    check("rst_valid", valid_o, 1'b0);
    check("rst_last", last_o, 1'b0);
    check("rst_dat", dat_o, 16'h0000);
    check("rst_busy", busy_o, 1'b0);
    check("rst_overrun", overrun_o, 1'b0);
    check("rst_bus_err", bus_err_o, 1'b0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk);

    // Basic frame, holdoff 3, sink always ready.
    q_dat.delete(); q_last.delete();
    first_stb_cyc = -1;
    send_update();
    wait_idle("s1_idle", 2000);
    check("s1_stb_latency", first_stb_cyc - upd_cyc, 5);
    check("s1_size", q_dat.size(), FRAME_LEN);
    check_frame(8'd0, 0, NO_ADR, NO_ADR);
    check("s1_overrun", overrun_o, 1'b0);
    check("s1_bus_err", bus_err_o, 1'b0);

    // Random back-pressure; stall stability is checked in the sink.
    q_dat.delete(); q_last.delete();
    n_stalls = 0;
    ready_mode = 1;
    send_update();
    wait_idle("s2_idle", 5000);
    ready_mode = 0;
    @(negedge clk);
    check("s2_stalls_seen", n_stalls > 0, 1'b1);
    check("s2_size", q_dat.size(), FRAME_LEN);
    check_frame(8'd1, 0, NO_ADR, NO_ADR);

    // Ack timeout on 0x0105 and err on 0x0110.
    q_dat.delete(); q_last.delete();
    no_ack_adr = 16'h0105;
    err_adr    = 16'h0110;
    to_len     = 0;
    send_update();
    wait_idle("s3_idle", 3000);
    check("s3_timeout_len", to_len, 15);
    check("s3_word2", q_dat.size() > 3 ? q_dat[3] : 16'h0, 16'hFF04);
    check_frame(8'd2, 0, 16'h0105, 16'h0110);
    check("s3_bus_err", bus_err_o, 1'b1);
    check("s3_overrun", overrun_o, 1'b0);
    no_ack_adr = NO_ADR;
    err_adr    = NO_ADR;
    pulse_clear();
    check("s3_bus_err_clr", bus_err_o, 1'b0);

    // Three updates during a frame: exactly one extra frame.
    q_dat.delete(); q_last.delete();
    send_update();
    repeat (3) begin
      repeat (30) @(negedge clk);
      send_update();
    end
    wait_idle("s4_idle", 5000);
    repeat (100) @(negedge clk);
    check("s4_still_idle", busy_o, 1'b0);
    check("s4_size", q_dat.size(), 2 * FRAME_LEN);
    check_frame(8'd3, 0, NO_ADR, NO_ADR);
    check_frame(8'd4, FRAME_LEN, NO_ADR, NO_ADR);
    check("s4_overrun", overrun_o, 1'b1);
    pulse_clear();
    check("s4_overrun_clr", overrun_o, 1'b0);

    // Disabled update is ignored; disabling mid-frame drops the pending one.
    enable_i = 1'b0;
    send_update();
    repeat (5) @(negedge clk);
    check("s5_ignored", busy_o, 1'b0);
    enable_i = 1'b1;
    q_dat.delete(); q_last.delete();
    send_update();
    repeat (10) @(negedge clk);
    enable_i = 1'b0;
    repeat (20) @(negedge clk);
    send_update();
    wait_idle("s5_idle", 3000);
    repeat (50) @(negedge clk);
    check("s5_still_idle", busy_o, 1'b0);
    check("s5_size", q_dat.size(), FRAME_LEN);
    check_frame(8'd5, 0, NO_ADR, NO_ADR);
    check("s5_overrun", overrun_o, 1'b1);
    enable_i = 1'b1;
    pulse_clear();

    // Reset during the RD_HI read of the pair holding byte 20.
    send_update();
    found = 1'b0;
    for (int n = 0; n < 2000 && !found; n++) begin
      @(negedge clk);
      if (stb_o && adr_o == 16'h0115) found = 1'b1;
    end
    check("s6_reached_rd", found, 1'b1);
    rst_i = 1'b1;
    @(negedge clk);
    check("s6_cyc", cyc_o, 1'b0);
    check("s6_stb", stb_o, 1'b0);
    check("s6_valid", valid_o, 1'b0);
    check("s6_busy", busy_o, 1'b0);
    rst_i = 1'b0;
    holdoff_i = 8'd0;
    q_dat.delete(); q_last.delete();
    repeat (2) @(negedge clk);
    first_valid_cyc = -1;
    send_update();
    wait_idle("s6_idle", 2000);
    check("s6_hdr_latency", first_valid_cyc - upd_cyc, 2);
    check("s6_size", q_dat.size(), FRAME_LEN);
    check_frame(8'd0, 0, NO_ADR, NO_ADR);

    // Bus discipline over the whole run.
    check("gap_between_reads", gap_viol, 0);
    check("read_while_valid", overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
